ber_sweep_ctrl: RTL and testbench
=================================

// Module: ber_sweep_ctrl
// PURPOSE
//  Sequences the BER evaluation loop around the IB layer decoder: requests one AWGN frame, launches one decode,
//  accumulates error bits, error frames, blocks and iterations, and advances the SNR point once ERR_FRAME_HALT
//  error frames (or MAX_BLOCK blocks) are collected. Sits between the AWGN generator / decoder top and the
//  statistics readout. Drives snr_packet, block_cnt, errFrame_cnt, err_cnt_acc, iter_cnt_acc and count_done.
// PARAMETERS
//  SNR_SET_NUM    8      number of SNR points in one sweep
//  START_SNR      20     snr_packet value of the first point (snr_packet = START_SNR + point index)
//  ERR_FRAME_HALT 100    error frames that close an SNR point
//  MAX_BLOCK      2**20  block cap that also closes an SNR point
//  ERRBIT_BW      13     width of per-frame error-bit count (N=7650)
//  ITER_BW        4      width of per-frame iteration count
//  ACC_BW         32     width of err_cnt_acc, iter_cnt_acc and block_cnt
//  SNR_BW         8      width of snr_packet
// PORTS
//  read_clk      in   1          single clock for the whole block
//  rstn          in   1          asynchronous, active-low reset
//  sweep_start   in   1          synchronous pulse; starts a sweep from IDLE or SWEEP_DONE
//  sweep_abort   in   1          synchronous; returns to IDLE from any state
//  awgn_req      out  1          one-cycle request for a new noisy frame
//  awgn_ready    in   1          pulse; requested frame is loaded into the channel RAM
//  dec_start     out  1          one-cycle decoder launch
//  dec_done      in   1          pulse; decode finished, dec_err_bits and dec_iter valid this cycle
//  dec_err_bits  in   ERRBIT_BW  bit errors of the finished frame
//  dec_iter      in   ITER_BW    iterations used by the finished frame
//  snr_packet    out  SNR_BW     current SNR code
//  block_cnt     out  ACC_BW     frames decoded at this point
//  errFrame_cnt  out  16         frames with dec_err_bits != 0 at this point
//  err_cnt_acc   out  ACC_BW     accumulated bit errors at this point
//  iter_cnt_acc  out  ACC_BW     accumulated iterations at this point
//  count_done    out  1          one-cycle pulse when a point closes; statistics stable that cycle
//  sweep_done    out  1          level; high in SWEEP_DONE
//  busy          out  1          high in every state except IDLE and SWEEP_DONE
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, except snr_packet = START_SNR.
//  - States: IDLE, REQ, WAIT_FRAME, DECODE, ACCUM, POINT_DONE, SWEEP_DONE.
//  - IDLE/SWEEP_DONE --sweep_start--> REQ. Point index = 0, snr_packet = START_SNR, all statistics cleared.
//  - REQ: awgn_req = 1 for exactly one cycle, then WAIT_FRAME.
//  - WAIT_FRAME --awgn_ready--> DECODE with dec_start = 1 in the first DECODE cycle only.
//  - DECODE --dec_done--> ACCUM. Latch dec_err_bits and dec_iter on the dec_done cycle.
//  - ACCUM takes one cycle:
//    - block_cnt += 1, err_cnt_acc += bits, iter_cnt_acc += iter; all three saturate at all-ones.
//    - errFrame_cnt += 1 when bits != 0.
//    - Next state is POINT_DONE if the updated errFrame_cnt == ERR_FRAME_HALT or the updated
//      block_cnt == MAX_BLOCK; otherwise REQ.
//  - POINT_DONE takes one cycle with count_done = 1.
//    - If point index == SNR_SET_NUM-1: go to SWEEP_DONE and hold snr_packet and statistics.
//    - Otherwise: increment index and snr_packet, clear the four counters the following cycle, go to REQ.
//  - Ignored inputs:
//    - awgn_ready outside WAIT_FRAME and dec_done outside DECODE.
//    - sweep_start while busy.
//    - dec_done and awgn_ready arriving in the same cycle: only the one valid for the current state acts.
//  - sweep_abort has priority over every transition: next cycle IDLE, awgn_req/dec_start/count_done = 0;
//    statistics hold their values.
//  - rstn asserted mid-decode: immediate return to reset values. No pending request is remembered.
//  - Latency: sweep_start to awgn_req = 1 cycle; awgn_ready to dec_start = 1 cycle;
//    dec_done to the next awgn_req = 2 cycles (ACCUM, then REQ).
// TESTING
//  1. ERR_FRAME_HALT=2, SNR_SET_NUM=1; frames return bits 0,5,0,7
//     -> count_done after the 4th ACCUM; block_cnt=4, errFrame_cnt=2, err_cnt_acc=12; sweep_done=1.
//  2. SNR_SET_NUM=3, START_SNR=20, every frame returns bits 1
//     -> snr_packet steps 20,21,22; exactly three count_done pulses; counters cleared at each new point.
//  3. MAX_BLOCK=5, all frames return bits 0
//     -> point closes at block_cnt=5 with errFrame_cnt=0.
//  4. Spurious dec_done in WAIT_FRAME, awgn_ready in DECODE, sweep_start while busy
//     -> no state change; counters unchanged.
//  5. Assert sweep_abort during DECODE -> IDLE next cycle, busy=0;
//     then sweep_start -> snr_packet=20, counters=0.
//  6. Drop rstn mid-DECODE -> all outputs at reset values asynchronously;
//     release, pulse sweep_start -> awgn_req one cycle later.

Source files
------------

// File: rtl/ber_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ber_sweep_ctrl
// Description : BER sweep sequencer around the layer decoder. It requests a
//               frame, decodes it, accumulates the statistics and steps the
//               SNR point.
// Revision    : 1.0 - initial release
// ============================================================================
module ber_sweep_ctrl #(
    parameter int SNR_SET_NUM    = 8,
    parameter int START_SNR      = 20,
    parameter int ERR_FRAME_HALT = 100,
    parameter int MAX_BLOCK      = 2**20,
    parameter int ERRBIT_BW      = 13,
    parameter int ITER_BW        = 4,
    parameter int ACC_BW         = 32,
    parameter int SNR_BW         = 8
) (
    input  logic                 read_clk,
    input  logic                 rstn,
    input  logic                 sweep_start,
    input  logic                 sweep_abort,
    output logic                 awgn_req,
    input  logic                 awgn_ready,
    output logic                 dec_start,
    input  logic                 dec_done,
    input  logic [ERRBIT_BW-1:0] dec_err_bits,
    input  logic [ITER_BW-1:0]   dec_iter,
    output logic [SNR_BW-1:0]    snr_packet,
    output logic [ACC_BW-1:0]    block_cnt,
    output logic [15:0]          errFrame_cnt,
    output logic [ACC_BW-1:0]    err_cnt_acc,
    output logic [ACC_BW-1:0]    iter_cnt_acc,
    output logic                 count_done,
    output logic                 sweep_done,
    output logic                 busy
);

    localparam int IDX_BW = (SNR_SET_NUM > 1) ? $clog2(SNR_SET_NUM) : 1;

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_REQ        = 3'd1;
    localparam logic [2:0] c_WAIT_FRAME = 3'd2;
    localparam logic [2:0] c_DECODE     = 3'd3;
    localparam logic [2:0] c_ACCUM      = 3'd4;
    localparam logic [2:0] c_POINT_DONE = 3'd5;
    localparam logic [2:0] c_SWEEP_DONE = 3'd6;

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [IDX_BW-1:0]    r_point_idx;
    logic [SNR_BW-1:0]    r_snr;
    logic [ACC_BW-1:0]    r_block;
    logic [15:0]          r_err_frame;
    logic [ACC_BW-1:0]    r_err_acc;
    logic [ACC_BW-1:0]    r_iter_acc;
    logic [ERRBIT_BW-1:0] r_bits;
    logic [ITER_BW-1:0]   r_iter;
    logic                 r_dec_start;

    logic [ACC_BW:0]      w_err_sum;
    logic [ACC_BW:0]      w_iter_sum;
    logic [ACC_BW-1:0]    w_block_next;
    logic [ACC_BW-1:0]    w_err_acc_next;
    logic [ACC_BW-1:0]    w_iter_acc_next;
    logic [15:0]          w_err_frame_next;
    logic                 w_halt;
    logic                 w_last_point;

    // Saturating accumulator updates; the halt test looks at the updated values.
    assign w_err_sum        = {1'b0, r_err_acc} + {{(ACC_BW+1-ERRBIT_BW){1'b0}}, r_bits};
    assign w_iter_sum       = {1'b0, r_iter_acc} + {{(ACC_BW+1-ITER_BW){1'b0}}, r_iter};
    assign w_err_acc_next   = w_err_sum[ACC_BW]  ? '1 : w_err_sum[ACC_BW-1:0];
    assign w_iter_acc_next  = w_iter_sum[ACC_BW] ? '1 : w_iter_sum[ACC_BW-1:0];
    assign w_block_next     = (&r_block) ? r_block : r_block + ACC_BW'(1);
    assign w_err_frame_next = ((r_bits != '0) && !(&r_err_frame)) ? r_err_frame + 16'd1
                                                                  : r_err_frame;
    assign w_halt           = (w_err_frame_next == 16'(ERR_FRAME_HALT)) ||
                              (w_block_next == ACC_BW'(MAX_BLOCK));
    assign w_last_point     = (r_point_idx == IDX_BW'(SNR_SET_NUM - 1));

    always_comb begin
        w_state_next = r_state;
        if (sweep_abort) begin
            w_state_next = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE, c_SWEEP_DONE: if (sweep_start) w_state_next = c_REQ;
                c_REQ:                w_state_next = c_WAIT_FRAME;
                c_WAIT_FRAME:         if (awgn_ready) w_state_next = c_DECODE;
                c_DECODE:             if (dec_done) w_state_next = c_ACCUM;
                c_ACCUM:              w_state_next = w_halt ? c_POINT_DONE : c_REQ;
                c_POINT_DONE:         w_state_next = w_last_point ? c_SWEEP_DONE : c_REQ;
                default:              w_state_next = c_IDLE;
            endcase
        end
    end

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= c_IDLE;
            r_dec_start <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_dec_start <= !sweep_abort && (r_state == c_WAIT_FRAME) && awgn_ready;
        end
    end

    // An abort freezes the statistics exactly as they stood.
    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            r_point_idx <= '0;
            r_snr       <= SNR_BW'(START_SNR);
            r_block     <= '0;
            r_err_frame <= '0;
            r_err_acc   <= '0;
            r_iter_acc  <= '0;
            r_bits      <= '0;
            r_iter      <= '0;
        end else if (!sweep_abort) begin
            case (r_state)
                c_IDLE, c_SWEEP_DONE: begin
                    if (sweep_start) begin
                        r_point_idx <= '0;
                        r_snr       <= SNR_BW'(START_SNR);
                        r_block     <= '0;
                        r_err_frame <= '0;
                        r_err_acc   <= '0;
                        r_iter_acc  <= '0;
                    end
                end
                c_DECODE: begin
                    if (dec_done) begin
                        r_bits <= dec_err_bits;
                        r_iter <= dec_iter;
                    end
                end
                c_ACCUM: begin
                    r_block     <= w_block_next;
                    r_err_frame <= w_err_frame_next;
                    r_err_acc   <= w_err_acc_next;
                    r_iter_acc  <= w_iter_acc_next;
                end
                c_POINT_DONE: begin
                    if (!w_last_point) begin
                        r_point_idx <= r_point_idx + IDX_BW'(1);
                        r_snr       <= r_snr + SNR_BW'(1);
                        r_block     <= '0;
                        r_err_frame <= '0;
                        r_err_acc   <= '0;
                        r_iter_acc  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign awgn_req     = (r_state == c_REQ);
    assign dec_start    = r_dec_start;
    assign count_done   = (r_state == c_POINT_DONE);
    assign sweep_done   = (r_state == c_SWEEP_DONE);
    assign busy         = (r_state != c_IDLE) && (r_state != c_SWEEP_DONE);
    assign snr_packet   = r_snr;
    assign block_cnt    = r_block;
    assign errFrame_cnt = r_err_frame;
    assign err_cnt_acc  = r_err_acc;
    assign iter_cnt_acc = r_iter_acc;

endmodule
`default_nettype wire

// File: tb/tb_ber_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ber_sweep_ctrl
// Description : Self-checking bench for ber_sweep_ctrl (3 points, halt at 2
//               error frames or 5 blocks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ber_sweep_ctrl;

    localparam int SNR_N = 3;
    localparam int START = 20;
    localparam int HALT  = 2;
    localparam int MAXB  = 5;

    logic        read_clk = 1'b0;
    logic        rstn;
    logic        sweep_start, sweep_abort, awgn_ready, dec_done;
    logic [12:0] dec_err_bits;
    logic [3:0]  dec_iter;
    logic        awgn_req, dec_start, count_done, sweep_done, busy;
    logic [7:0]  snr_packet;
    logic [31:0] block_cnt, err_cnt_acc, iter_cnt_acc;
    logic [15:0] errFrame_cnt;

    always #5 read_clk = ~read_clk;

    ber_sweep_ctrl #(
        .SNR_SET_NUM(SNR_N), .START_SNR(START), .ERR_FRAME_HALT(HALT), .MAX_BLOCK(MAXB),
        .ERRBIT_BW(13), .ITER_BW(4), .ACC_BW(32), .SNR_BW(8)
    ) dut (
        .read_clk(read_clk), .rstn(rstn), .sweep_start(sweep_start), .sweep_abort(sweep_abort),
        .awgn_req(awgn_req), .awgn_ready(awgn_ready), .dec_start(dec_start), .dec_done(dec_done),
        .dec_err_bits(dec_err_bits), .dec_iter(dec_iter), .snr_packet(snr_packet),
        .block_cnt(block_cnt), .errFrame_cnt(errFrame_cnt), .err_cnt_acc(err_cnt_acc),
        .iter_cnt_acc(iter_cnt_acc), .count_done(count_done), .sweep_done(sweep_done), .busy(busy)
    );

    typedef struct {
        logic [3:0]  in_f;   // {sweep_start, sweep_abort, awgn_ready, dec_done}
        logic [12:0] bits;
        logic [3:0]  iter;
        logic [4:0]  e_f;    // {awgn_req, dec_start, count_done, sweep_done, busy}
        logic [31:0] e_blk;
        logic [15:0] e_ef;
        logic [31:0] e_err;
        logic [31:0] e_it;
        logic [7:0]  e_snr;
    } vec_t;

    vec_t tbl [22];
    int   total = 0;
    int   bad = 0;
    int   cd_pulses = 0;
    int   m_pt, m_blk, m_ef, m_err, m_it;
    bit   m_done;

    always @(negedge read_clk) if (count_done === 1'b1) cd_pulses++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] inf, input int b, input int it, input logic [4:0] ef,
                                input int blk, input int efc, input int err, input int itr, input int snr);
        vec_t v;
        v.in_f = inf; v.bits = 13'(b); v.iter = 4'(it); v.e_f = ef;
        v.e_blk = 32'(blk); v.e_ef = 16'(efc); v.e_err = 32'(err); v.e_it = 32'(itr); v.e_snr = 8'(snr);
        return v;
    endfunction

    function automatic logic [119:0] stats();
        return {block_cnt, errFrame_cnt, err_cnt_acc, iter_cnt_acc, snr_packet};
    endfunction

    function automatic logic [119:0] model();
        return {32'(m_blk), 16'(m_ef), 32'(m_err), 32'(m_it), 8'(START + m_pt)};
    endfunction

    function automatic logic [124:0] outs();
        return {awgn_req, dec_start, count_done, sweep_done, busy, stats()};
    endfunction

    task automatic start_sweep();
        sweep_start = 1'b1;
        @(negedge read_clk);
        sweep_start = 1'b0;
        m_pt = 0; m_blk = 0; m_ef = 0; m_err = 0; m_it = 0; m_done = 0;
        chk("start", 128'(outs()), 128'({5'b10001, model()}));
    endtask

    // One frame transaction; the model then decides whether this frame closes the point.
    task automatic do_frame(input int b, input int it);
        int n;
        int rd;
        int dd;
        n = 0;
        while (awgn_req !== 1'b1 && n < 20) begin
            @(negedge read_clk);
            n++;
        end
        chk("req_wait", 128'(awgn_req), 128'(1));
        rd = int'($urandom_range(0, 3));
        dd = int'($urandom_range(0, 3));
        @(negedge read_clk);
        repeat (rd) @(negedge read_clk);
        awgn_ready = 1'b1;
        @(negedge read_clk);
        awgn_ready = 1'b0;
        chk("dec_start", 128'(dec_start), 128'(1));
        repeat (dd) @(negedge read_clk);
        dec_err_bits = 13'(b);
        dec_iter = 4'(it);
        dec_done = 1'b1;
        @(negedge read_clk);
        dec_done = 1'b0;
        @(negedge read_clk);
        m_blk++;
        if (b != 0) m_ef++;
        m_err += b;
        m_it += it;
        if (m_ef == HALT || m_blk == MAXB) begin
            chk("point_close", 128'({count_done, awgn_req, stats()}), 128'({2'b10, model()}));
            if (m_pt == SNR_N - 1) begin
                @(negedge read_clk);
                chk("sweep_end", 128'({sweep_done, busy, stats()}), 128'({2'b10, model()}));
                m_done = 1;
            end else begin
                m_pt++; m_blk = 0; m_ef = 0; m_err = 0; m_it = 0;
                @(negedge read_clk);
                chk("next_point", 128'({awgn_req, count_done, stats()}), 128'({2'b10, model()}));
            end
        end else begin
            chk("frame_stats", 128'({count_done, awgn_req, stats()}), 128'({2'b01, model()}));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        {sweep_start, sweep_abort, awgn_ready, dec_done} = 4'b0;
        dec_err_bits = '0;
        dec_iter = '0;
        repeat (3) @(negedge read_clk);
        chk("reset_vals", 128'(outs()), 128'({5'b0, 32'd0, 16'd0, 32'd0, 32'd0, 8'd20}));
        rstn = 1'b1;

        // Spurious inputs, then the 0,5,0,7 point; iterations 2,3,4,6.
        tbl[0]  = mk(4'b0000, 0, 0, 5'b00000, 0, 0, 0, 0, 20);
        tbl[1]  = mk(4'b0011, 9, 4, 5'b00000, 0, 0, 0, 0, 20);
        tbl[2]  = mk(4'b1000, 0, 0, 5'b10001, 0, 0, 0, 0, 20);
        tbl[3]  = mk(4'b1000, 0, 0, 5'b00001, 0, 0, 0, 0, 20);
        tbl[4]  = mk(4'b0001, 3, 1, 5'b00001, 0, 0, 0, 0, 20);
        tbl[5]  = mk(4'b0011, 3, 1, 5'b01001, 0, 0, 0, 0, 20);
        tbl[6]  = mk(4'b1010, 0, 0, 5'b00001, 0, 0, 0, 0, 20);
        tbl[7]  = mk(4'b0001, 0, 2, 5'b00001, 0, 0, 0, 0, 20);
        tbl[8]  = mk(4'b0000, 0, 0, 5'b10001, 1, 0, 0, 2, 20);
        tbl[9]  = mk(4'b0000, 0, 0, 5'b00001, 1, 0, 0, 2, 20);
        tbl[10] = mk(4'b0010, 0, 0, 5'b01001, 1, 0, 0, 2, 20);
        tbl[11] = mk(4'b0001, 5, 3, 5'b00001, 1, 0, 0, 2, 20);
        tbl[12] = mk(4'b0000, 0, 0, 5'b10001, 2, 1, 5, 5, 20);
        tbl[13] = mk(4'b0000, 0, 0, 5'b00001, 2, 1, 5, 5, 20);
        tbl[14] = mk(4'b0010, 0, 0, 5'b01001, 2, 1, 5, 5, 20);
        tbl[15] = mk(4'b0001, 0, 4, 5'b00001, 2, 1, 5, 5, 20);
        tbl[16] = mk(4'b0000, 0, 0, 5'b10001, 3, 1, 5, 9, 20);
        tbl[17] = mk(4'b0000, 0, 0, 5'b00001, 3, 1, 5, 9, 20);
        tbl[18] = mk(4'b0010, 0, 0, 5'b01001, 3, 1, 5, 9, 20);
        tbl[19] = mk(4'b0001, 7, 6, 5'b00001, 3, 1, 5, 9, 20);
        tbl[20] = mk(4'b0000, 0, 0, 5'b00101, 4, 2, 12, 15, 20);
        tbl[21] = mk(4'b0000, 0, 0, 5'b10001, 0, 0, 0, 0, 21);

        for (int i = 0; i < 22; i++) begin
            {sweep_start, sweep_abort, awgn_ready, dec_done} = tbl[i].in_f;
            dec_err_bits = tbl[i].bits;
            dec_iter = tbl[i].iter;
            @(negedge read_clk);
            chk($sformatf("vec%0d", i), 128'(outs()),
                128'({tbl[i].e_f, tbl[i].e_blk, tbl[i].e_ef, tbl[i].e_err, tbl[i].e_it, tbl[i].e_snr}));
        end
        {sweep_start, sweep_abort, awgn_ready, dec_done} = 4'b0;

        // Point 1: error-free frames close on the block cap.
        m_pt = 1; m_blk = 0; m_ef = 0; m_err = 0; m_it = 0; m_done = 0;
        for (int k = 0; k < 5; k++) do_frame(0, 1);
        // Point 2: every frame in error; last point ends the sweep.
        do_frame(1, 2);
        do_frame(1, 2);
        chk("sweep_done_flag", 128'(m_done), 128'(1));
        chk("cd_pulses", 128'(cd_pulses), 128'(3));

        // Abort during DECODE (with a coincident dec_done) freezes statistics.
        start_sweep();
        do_frame(4, 3);
        @(negedge read_clk);
        awgn_ready = 1'b1;
        @(negedge read_clk);
        awgn_ready = 1'b0;
        chk("abort_dec_start", 128'(dec_start), 128'(1));
        sweep_abort = 1'b1;
        dec_done = 1'b1;
        dec_err_bits = 13'd6;
        @(negedge read_clk);
        sweep_abort = 1'b0;
        chk("abort_idle", 128'(outs()), 128'({5'b00000, 32'd1, 16'd1, 32'd4, 32'd3, 8'd20}));
        @(negedge read_clk);
        dec_done = 1'b0;
        chk("abort_hold", 128'(outs()), 128'({5'b00000, 32'd1, 16'd1, 32'd4, 32'd3, 8'd20}));
        start_sweep();

        // Reset asserted in the first DECODE cycle of point 1.
        do_frame(1, 1);
        do_frame(1, 1);
        do_frame(0, 1);
        @(negedge read_clk);
        awgn_ready = 1'b1;
        @(negedge read_clk);
        awgn_ready = 1'b0;
        chk("pre_rst_state", 128'({dec_start, busy, snr_packet, block_cnt}), 128'({2'b11, 8'd21, 32'd1}));
        #2 rstn = 1'b0;
        #1 chk("async_rst", 128'(outs()), 128'({5'b0, 32'd0, 16'd0, 32'd0, 32'd0, 8'd20}));
        @(negedge read_clk);
        rstn = 1'b1;
        @(negedge read_clk);
        chk("post_rst_idle", 128'({awgn_req, busy}), 128'(0));
        start_sweep();

        // Randomized sweeps against the transaction-level model.
        for (int s = 0; s < 3; s++) begin
            int guard;
            if (s > 0) start_sweep();
            guard = 0;
            while (!m_done && guard < 40) begin
                int b;
                b = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8191)) : 0;
                do_frame(b, int'($urandom_range(0, 15)));
                guard++;
            end
            chk($sformatf("rand_sweep%0d_end", s), 128'(m_done), 128'(1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
